branch_target_buffer: RTL and testbench
=======================================

# branch_target_buffer

Fetch-stage branch predictor and target cache: the partner of the MEM-stage branch-resolution logic. On every cycle it looks up the current fetch PC and produces a predicted-taken bit and a next-fetch PC. It is trained by the MEM stage's resolved outcome (update strobe, branch PC, target, taken) through a single write port. Direct-mapped, one entry per index, with 2-bit saturating direction counters.

## Interface
- ENTRIES, 16: number of entries; power of two, 2..256.
- INDEX_BITS, $clog2(ENTRIES): index width; derived, not overridden.
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_pc  input  32  PC being fetched this cycle.
- predicted_taken  output  1  lookup hit and counter in a taken state.
- predicted_pc  output  32  next fetch PC: stored target if predicted_taken, else fetch_pc + 4.
- update_en  input  1  MEM stage resolved a jump or branch this cycle (driven by the MEM stage's update_btb).
- update_pc  input  32  PC of the resolved instruction.
- update_target  input  32  resolved jump/branch target address.
- update_taken  input  1  resolved outcome: 1 = taken (jumps are always 1).
- flush  input  1  synchronous invalidate of all entries.

## Operation
- Entry fields: valid (1), tag (30 − INDEX_BITS), target (30, word address; stored target[31:2], bits [1:0] read back as 0), ctr (2).
- Index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2].
- Lookup (combinational from registered state): hit = valid[idx] && tag[idx] == fetch_pc tag; predicted_taken = hit && ctr[idx][1]; predicted_pc = predicted_taken ? {target[idx], 2'b00} : fetch_pc + 32'd4 (mod 2^32, 0xFFFFFFFC wraps to 0x00000000).
- Update when update_en && !flush, at entry idx(update_pc):
  - Hit, taken: ctr = sat_inc(ctr) (max 2'b11); target = update_target[31:2].
  - Hit, not taken: ctr = sat_dec(ctr) (min 2'b00); target unchanged.
  - Miss, taken: allocate, overwriting any existing entry: valid=1, tag, target, ctr = 2'b10 (weakly taken).
  - Miss, not taken: no change.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- flush: clears every valid bit at the next edge. Flush has priority over a simultaneous update; that update is dropped.
- update_target bits [1:0] are ignored. The JALR LSB clear is already applied upstream.

## Timing
- Lookup latency: zero cycles (same-cycle combinational output from registers).
- Update latency: the write takes effect at the rising edge. A lookup in the same cycle, at the same index, sees pre-update state (see Configuration).
- Reset (rst_n low, asynchronous): all valid = 0, ctr = 2'b00, tag = 0, target = 0. Outputs immediately: predicted_taken = 0, predicted_pc = fetch_pc + 4.
- Reset asserted during an update edge: reset wins; no entry is written.
- Back-to-back updates to the same entry on consecutive cycles each apply in order (counter steps once per cycle).
- No stall input: when fetch stalls, it holds fetch_pc, and the outputs track the state.

## Configuration
- BTB_BYPASS_EN defined:
  - When update_en && !flush && idx(update_pc) == idx(fetch_pc) && full update_pc tag matches fetch_pc, the lookup uses the post-update entry value in the same cycle.
  - Adds a comparator and muxing in front of the lookup outputs.
- BTB_BYPASS_EN undefined: the lookup always reads registered state; the update is visible from the next cycle.

## Test plan
- Reset, then fetch_pc=0x100 -> predicted_taken=0, predicted_pc=0x104; also check with rst_n asserted mid-run after training.
- Update pc=0x100, target=0x200, taken=1; next cycle fetch 0x100 -> predicted_taken=1, predicted_pc=0x200 (ctr=10).
- Three taken updates, then one not-taken, on 0x100 -> ctr 10→11→11→10, still predicted taken; a further two not-taken -> ctr 00, predicted_pc=0x104.
- Alias: train 0x100 taken, then update 0x140 taken target 0x300 (same index, ENTRIES=16) -> fetch 0x100 misses (0x104), fetch 0x140 -> 0x300; miss not-taken on 0x180 leaves the entry intact.
- flush and update on the same cycle -> all lookups miss next cycle; fetch_pc=0xFFFFFFFC on a miss -> predicted_pc=0x00000000.
- Same-cycle update and lookup of 0x100 -> old prediction without BTB_BYPASS_EN; new prediction with it.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Optional same-cycle update-to-lookup forwarding is enabled by defining BTB_BYPASS_EN.
module branch_target_buffer #(
    parameter  int ENTRIES    = 16,
    localparam int INDEX_BITS = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] fetch_pc,
    output logic        predicted_taken,
    output logic [31:0] predicted_pc,
    input  logic        update_en,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_taken,
    input  logic        flush
);

    localparam int TAG_W = 30 - INDEX_BITS;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic              valid_r  [ENTRIES];
    logic [TAG_W-1:0]  tag_r    [ENTRIES];
    logic [29:0]       target_r [ENTRIES];
    logic [1:0]        ctr_r    [ENTRIES];

    logic [INDEX_BITS-1:0] upd_idx_s;
    logic [TAG_W-1:0]      upd_tag_s;
    logic                  upd_hit_s;
    logic                  wr_en_s;
    logic [29:0]           new_target_s;
    logic [1:0]            new_ctr_s;

    logic [INDEX_BITS-1:0] fetch_idx_s;
    logic [TAG_W-1:0]      fetch_tag_s;
    logic                  lk_hit_s;
    logic [29:0]           lk_target_s;
    logic [1:0]            lk_ctr_s;
    logic                  unused_bits_s;

    assign upd_idx_s     = update_pc[INDEX_BITS+1:2];
    assign upd_tag_s     = update_pc[31:INDEX_BITS+2];
    assign upd_hit_s     = valid_r[upd_idx_s] && (tag_r[upd_idx_s] == upd_tag_s);
    assign fetch_idx_s   = fetch_pc[INDEX_BITS+1:2];
    assign fetch_tag_s   = fetch_pc[31:INDEX_BITS+2];
    assign unused_bits_s = ^{fetch_pc[1:0], update_pc[1:0], update_target[1:0]};

    // Compute the post-update value of the entry addressed by update_pc
    always_comb begin
        wr_en_s      = 1'b0;
        new_target_s = target_r[upd_idx_s];
        new_ctr_s    = ctr_r[upd_idx_s];
        if (update_en && !flush) begin
            if (upd_hit_s) begin
                wr_en_s = 1'b1;
                if (update_taken) begin
                    new_ctr_s    = sat_inc(ctr_r[upd_idx_s]);
                    new_target_s = update_target[31:2];
                end else begin
                    new_ctr_s    = sat_dec(ctr_r[upd_idx_s]);
                end
            end else if (update_taken) begin
                wr_en_s      = 1'b1;
                new_ctr_s    = 2'b10;
                new_target_s = update_target[31:2];
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Entry storage: flush clears valid bits only and drops any same-cycle update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                target_r[i] <= 30'd0;
                ctr_r[i]    <= 2'b00;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else if (wr_en_s) begin
            valid_r[upd_idx_s]  <= 1'b1;
            tag_r[upd_idx_s]    <= upd_tag_s;
            target_r[upd_idx_s] <= new_target_s;
            ctr_r[upd_idx_s]    <= new_ctr_s;
        end
    end

    // Lookup of the fetch PC, optionally forwarding the entry being written this cycle
    always_comb begin
        lk_hit_s    = valid_r[fetch_idx_s] && (tag_r[fetch_idx_s] == fetch_tag_s);
        lk_target_s = target_r[fetch_idx_s];
        lk_ctr_s    = ctr_r[fetch_idx_s];
`ifdef BTB_BYPASS_EN
        if (wr_en_s && (upd_idx_s == fetch_idx_s) && (upd_tag_s == fetch_tag_s)) begin
            lk_hit_s    = 1'b1;
            lk_target_s = new_target_s;
            lk_ctr_s    = new_ctr_s;
        end else begin
            lk_hit_s    = valid_r[fetch_idx_s] && (tag_r[fetch_idx_s] == fetch_tag_s);
        end
`endif
        predicted_taken = lk_hit_s && lk_ctr_s[1];
        if (predicted_taken) begin
            predicted_pc = {lk_target_s, 2'b00};
        end else begin
            predicted_pc = fetch_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (ENTRIES = 16).
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        predicted_taken;
    logic [31:0] predicted_pc;
    logic        update_en;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;
    logic        flush;

    int checks_cnt = 0;
    int errors_cnt = 0;

    branch_target_buffer #(.ENTRIES(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_pc        (fetch_pc),
        .predicted_taken (predicted_taken),
        .predicted_pc    (predicted_pc),
        .update_en       (update_en),
        .update_pc       (update_pc),
        .update_target   (update_target),
        .update_taken    (update_taken),
        .flush           (flush)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic look(input logic [31:0] pc, input logic et, input logic [31:0] ep, input string nm);
        fetch_pc = pc;
        #1;
        check_eq({nm, "_taken"}, {31'd0, predicted_taken}, {31'd0, et});
        check_eq({nm, "_pc"}, predicted_pc, ep);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk);
        update_en     = 1'b1;
        update_pc     = pc;
        update_target = tgt;
        update_taken  = tk;
        @(posedge clk);
        #1;
        update_en = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        fetch_pc      = 32'h0000_0100;
        update_en     = 1'b0;
        update_pc     = 32'd0;
        update_target = 32'd0;
        update_taken  = 1'b0;
        flush         = 1'b0;
        look(32'h0000_0100, 1'b0, 32'h0000_0104, "reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Allocate, then step the counter through saturation and back down
        upd(32'h0000_0100, 32'h0000_0200, 1'b1);
        look(32'h0000_0100, 1'b1, 32'h0000_0200, "alloc");
        upd(32'h0000_0100, 32'h0000_0240, 1'b1);
        upd(32'h0000_0100, 32'h0000_0240, 1'b1);
        look(32'h0000_0100, 1'b1, 32'h0000_0240, "strong_t");
        upd(32'h0000_0100, 32'h0000_0999, 1'b0);
        look(32'h0000_0100, 1'b1, 32'h0000_0240, "weak_t");
        upd(32'h0000_0100, 32'h0000_0240, 1'b0);
        look(32'h0000_0100, 1'b0, 32'h0000_0104, "weak_nt");
        upd(32'h0000_0100, 32'h0000_0240, 1'b0);
        look(32'h0000_0100, 1'b0, 32'h0000_0104, "strong_nt");
        upd(32'h0000_0100, 32'h0000_0240, 1'b1);
        look(32'h0000_0100, 1'b0, 32'h0000_0104, "nt_floor");
        upd(32'h0000_0100, 32'h0000_0200, 1'b1);
        look(32'h0000_0100, 1'b1, 32'h0000_0200, "retrain");

        // Aliasing at index 0 and miss-not-taken leaving the entry untouched
        upd(32'h0000_0140, 32'h0000_0300, 1'b1);
        look(32'h0000_0100, 1'b0, 32'h0000_0104, "alias_old");
        look(32'h0000_0140, 1'b1, 32'h0000_0300, "alias_new");
        upd(32'h0000_0180, 32'h0000_0500, 1'b0);
        look(32'h0000_0140, 1'b1, 32'h0000_0300, "miss_nt");
        look(32'h0000_0180, 1'b0, 32'h0000_0184, "miss_nt_other");
        upd(32'h0000_0104, 32'h0000_0800, 1'b1);
        look(32'h0000_0104, 1'b1, 32'h0000_0800, "idx1");
        look(32'h0000_0140, 1'b1, 32'h0000_0300, "idx0_kept");

        // Flush wins over a simultaneous update
        flush = 1'b1;
        upd(32'h0000_0108, 32'h0000_0900, 1'b1);
        flush = 1'b0;
        look(32'h0000_0140, 1'b0, 32'h0000_0144, "flush_a");
        look(32'h0000_0104, 1'b0, 32'h0000_0108, "flush_b");
        look(32'h0000_0108, 1'b0, 32'h0000_010C, "flush_upd");
        look(32'hFFFF_FFFC, 1'b0, 32'h0000_0000, "wrap");

        // Same-cycle update and lookup of the same PC
        fetch_pc      = 32'h0000_0100;
        update_en     = 1'b1;
        update_pc     = 32'h0000_0100;
        update_target = 32'h0000_0200;
        update_taken  = 1'b1;
`ifdef BTB_BYPASS_EN
        look(32'h0000_0100, 1'b1, 32'h0000_0200, "same_cycle");
`else
        look(32'h0000_0100, 1'b0, 32'h0000_0104, "same_cycle");
`endif
        @(posedge clk);
        #1;
        update_en = 1'b0;
        look(32'h0000_0100, 1'b1, 32'h0000_0200, "next_cycle");

        // Asynchronous reset mid-run, held across an update edge
        rst_n = 1'b0;
        look(32'h0000_0100, 1'b0, 32'h0000_0104, "mid_reset");
        upd(32'h0000_0100, 32'h0000_0200, 1'b1);
        rst_n = 1'b1;
        look(32'h0000_0100, 1'b0, 32'h0000_0104, "reset_upd");
        upd(32'h0000_0100, 32'h0000_0200, 1'b0);
        look(32'h0000_0100, 1'b0, 32'h0000_0104, "post_reset_nt");

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
